// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: command codes, error bit
// positions and the issuer state encoding.
package alu_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_MUL = 4'd3;
    localparam logic [3:0] CMD_DIV = 4'd4;
    localparam logic [3:0] CMD_MOD = 4'd5;

    localparam int ERR_DBZ = 1;
    localparam int ERR_OVF = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } issuer_state_t;

endpackage

// File: rtl/alu_cmd_issuer.sv
// Sequential front-end for the combinational 16-bit ALU: takes one request at
// a time, holds the ALU inputs for SETTLE_CYCLES, captures result/error,
// returns them over a valid/ready response channel and keeps an accumulator
// plus sticky error flags.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cmd,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic        req_use_acc,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_cmd,
    input  logic [31:0] alu_result,
    input  logic [1:0]  alu_error,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [1:0]  rsp_error,
    output logic [31:0] acc,
    output logic [1:0]  err_sticky,
    input  logic        err_clr,
    output logic        busy
);

    // Counter counts down to zero, so capture lands SETTLE_CYCLES edges after accept.
    localparam logic [3:0] LP_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    issuer_state_t r_state;
    issuer_state_t w_state_nxt;
    logic [3:0]    r_cnt;
    logic          r_out_en;
    logic [15:0]   r_alu_a;
    logic [15:0]   r_alu_b;
    logic [3:0]    r_alu_cmd;
    logic [31:0]   r_rsp_result;
    logic [1:0]    r_rsp_error;
    logic [31:0]   r_acc;
    logic [1:0]    r_err_sticky;
    logic          w_req_ready;
    logic          w_accept;
    logic          w_capture;
    logic          w_rsp_done;

    // req_ready is low during reset and only rises on the first edge after
    // release, so it stays a pure register decode.
    assign w_req_ready = r_out_en && (r_state == IDLE);

    // Next-state and transaction strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid && w_req_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (r_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Output enable: holds req_ready off until the first edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_out_en <= 1'b0;
        else        r_out_en <= 1'b1;
    end

    // Settle counter: loaded on accept, counts down while driving the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_cnt <= 4'd0;
        else if (w_accept)                         r_cnt <= LP_SETTLE_LOAD;
        else if (r_state == DRIVE && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end

    // ALU operand/command registers; command drops to NOP once the response is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_cmd <= CMD_NOP;
        end else if (w_accept) begin
            r_alu_a   <= req_use_acc ? r_acc[15:0] : req_a;
            r_alu_b   <= req_b;
            r_alu_cmd <= req_cmd;
        end else if (w_rsp_done) begin
            r_alu_cmd <= CMD_NOP;
        end
    end

    // Result capture into the response registers and the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_result <= '0;
            r_rsp_error  <= '0;
            r_acc        <= '0;
        end else if (w_capture) begin
            r_rsp_result <= alu_result;
            r_rsp_error  <= alu_error;
            r_acc        <= alu_result;
        end
    end

    // Sticky errors: a capture on the clear edge still sets its bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err_sticky <= '0;
        else        r_err_sticky <= (err_clr ? 2'b00 : r_err_sticky)
                                    | (w_capture ? alu_error : 2'b00);
    end

    assign req_ready  = w_req_ready;
    assign rsp_valid  = (r_state == RESP);
    assign busy       = (r_state != IDLE);
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_cmd    = r_alu_cmd;
    assign rsp_result = r_rsp_result;
    assign rsp_error  = r_rsp_error;
    assign acc        = r_acc;
    assign err_sticky = r_err_sticky;

endmodule
